// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, buffers returned words in a 2-entry FIFO
// and hands them to decode over valid/ready. Handles redirects and sticky fetch faults.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned IMEM_ADDR_BITS = 15
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus4,
   output logic        fault
);

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] head_pc_q, head_pc_d, head_instr_q, head_instr_d;
   logic [31:0] tail_pc_q, tail_pc_d, tail_instr_q, tail_instr_d;
   logic [1:0]  count_q, count_d;
   logic        fault_q, fault_d;

   logic        pop, push, try_push, fetch_ok, redirect_take;
   logic [1:0]  occ_after_pop;

   assign out_valid     = (count_q != 2'd0);
   assign pop           = out_valid & out_ready;
   assign fetch_ok      = (fetch_pc_q[1:0] == 2'b00) && ((fetch_pc_q >> IMEM_ADDR_BITS) == 32'd0);
   assign try_push      = ~fault_q & ~redirect_valid & ((count_q != 2'd2) | pop);
   assign push          = try_push & fetch_ok;
   assign redirect_take = redirect_valid & ~fault_q;
   assign occ_after_pop = count_q - {1'b0, pop};

   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      head_pc_d    = head_pc_q;
      head_instr_d = head_instr_q;
      tail_pc_d    = tail_pc_q;
      tail_instr_d = tail_instr_q;
      count_d      = count_q;
      fault_d      = fault_q;

      if (redirect_take) begin
         // Flush; a same-cycle pop was still accepted by decode.
         count_d    = 2'd0;
         fetch_pc_d = redirect_pc;
      end else begin
         if (pop) begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
         end
         if (push) begin
            if (occ_after_pop == 2'd0) begin
               head_pc_d    = fetch_pc_q;
               head_instr_d = imem_instr;
            end else begin
               tail_pc_d    = fetch_pc_q;
               tail_instr_d = imem_instr;
            end
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         count_d = occ_after_pop + {1'b0, push};
         if (try_push && !fetch_ok) begin
            fault_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q   <= RESET_PC;
         head_pc_q    <= '0;
         head_instr_q <= '0;
         tail_pc_q    <= '0;
         tail_instr_q <= '0;
         count_q      <= 2'd0;
         fault_q      <= 1'b0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         head_pc_q    <= head_pc_d;
         head_instr_q <= head_instr_d;
         tail_pc_q    <= tail_pc_d;
         tail_instr_q <= tail_instr_d;
         count_q      <= count_d;
         fault_q      <= fault_d;
      end
   end

   assign imem_addr    = fetch_pc_q;
   assign fault        = fault_q;
   assign out_instr    = out_valid ? head_instr_q : 32'd0;
   assign out_pc       = out_valid ? head_pc_q : 32'd0;
   assign out_pc_plus4 = out_valid ? (head_pc_q + 32'd4) : 32'd0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: expected PCs are queued by the stimulus thread and
// a negedge monitor checks every accepted instruction against the queue head.
module tb_if_fetch_stage;

   localparam logic [31:0] KEY = 32'hC0DE_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr, imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid, out_ready;
   logic [31:0] out_instr, out_pc, out_pc_plus4;
   logic        fault;

   int vectors = 0;
   int errors  = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   // Memory model: word differs from its address so pc/instr swaps are visible.
   assign imem_instr = imem_addr ^ KEY;

   if_fetch_stage #(
      .RESET_PC       (32'h0000_0000),
      .IMEM_ADDR_BITS (15)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc_plus4   (out_pc_plus4),
      .fault          (fault)
   );

   // Monitor: every accepted instruction must match the queue head.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_delivery: got pc=%h, required no delivery", out_pc);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (out_pc !== e || out_instr !== (e ^ KEY) || out_pc_plus4 !== e + 32'd4) begin
               errors++;
               $display("FAIL delivery: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                        out_pc, out_instr, out_pc_plus4, e, e ^ KEY, e + 32'd4);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
   endtask

   task automatic drained(input string name);
      chk(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic chk_reset_state(input string name);
      chk({name, "_valid"}, {31'd0, out_valid}, 0);
      chk({name, "_instr"}, out_instr, 0);
      chk({name, "_pc"}, out_pc, 0);
      chk({name, "_pc4"}, out_pc_plus4, 0);
      chk({name, "_addr"}, imem_addr, 0);
      chk({name, "_fault"}, {31'd0, fault}, 0);
   endtask

   initial begin
      reset          = 1'b1;
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // Streaming after reset release.
      cyc(2);
      chk_reset_state("rst");
      for (int i = 0; i < 7; i++) exp_q.push_back(32'(4 * i));
      reset = 1'b0;
      chk("first_cycle_invalid", {31'd0, out_valid}, 0);
      cyc(1);
      chk("first_valid", {31'd0, out_valid}, 1);
      chk("first_pc", out_pc, 32'h0);
      cyc(7);
      out_ready = 1'b0;
      drained("stream_drained");

      // Backpressure then back-to-back release.
      do_reset();
      cyc(5);
      chk("bp_addr_hold", imem_addr, 32'h8);
      chk("bp_head", out_pc, 32'h0);
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      exp_q.push_back(32'h8); exp_q.push_back(32'hC);
      out_ready = 1'b1;
      cyc(4);
      out_ready = 1'b0;
      drained("bp_drained");

      // Redirect while full with 0x10/0x14.
      do_reset();
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      exp_q.push_back(32'h8); exp_q.push_back(32'hC);
      out_ready = 1'b1;
      cyc(5);
      out_ready = 1'b0;
      cyc(1);
      chk("full_head", out_pc, 32'h10);
      chk("full_addr", imem_addr, 32'h18);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      cyc(1);
      redirect_valid = 1'b0;
      chk("redir_bubble", {31'd0, out_valid}, 0);
      exp_q.push_back(32'h100); exp_q.push_back(32'h104);
      out_ready = 1'b1;
      cyc(1);
      chk("redir_target", out_pc, 32'h100);
      cyc(2);
      out_ready = 1'b0;
      drained("redir_drained");

      // Misaligned redirect -> sticky fault, later redirect ignored.
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      cyc(1);
      redirect_valid = 1'b0;
      chk("mis_no_fault_yet", {31'd0, fault}, 0);
      cyc(1);
      chk("mis_fault", {31'd0, fault}, 1);
      chk("mis_addr", imem_addr, 32'h102);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      cyc(1);
      redirect_valid = 1'b0;
      out_ready = 1'b1;
      cyc(2);
      chk("fault_ignores_redir", imem_addr, 32'h102);
      chk("fault_no_valid", {31'd0, out_valid}, 0);
      chk("fault_sticky", {31'd0, fault}, 1);
      out_ready = 1'b0;
      do_reset();
      chk("fault_cleared", {31'd0, fault}, 0);
      chk("refetch_addr", imem_addr, 32'h0);
      exp_q.push_back(32'h0);
      out_ready = 1'b1;
      cyc(2);
      out_ready = 1'b0;
      drained("refetch_drained");

      // Running off the end of instruction memory.
      do_reset();
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h7FF8;
      cyc(1);
      redirect_valid = 1'b0;
      exp_q.push_back(32'h7FF8); exp_q.push_back(32'h7FFC);
      cyc(4);
      chk("range_fault", {31'd0, fault}, 1);
      chk("range_addr", imem_addr, 32'h8000);
      chk("range_no_valid", {31'd0, out_valid}, 0);
      out_ready = 1'b0;
      drained("range_drained");

      // Reset while full with a redirect pending.
      do_reset();
      cyc(3);
      chk("pre_reset_full", {31'd0, out_valid}, 1);
      chk("pre_reset_addr", imem_addr, 32'h8);
      reset          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      cyc(1);
      reset          = 1'b0;
      redirect_valid = 1'b0;
      chk_reset_state("midrst");
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      out_ready = 1'b1;
      cyc(3);
      out_ready = 1'b0;
      drained("midrst_drained");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
